mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters.
- Requester C is the CPU controller/datapath (fetch, operand fetch, store). Requester D is a DMA/debug loader.
- Serialises accesses through one memory port with a fixed, parameterised read latency, and returns a one-cycle ack with read data to the owning requester.

Parameters:
ADDR_W, 13, memory address width
DATA_W, 8, memory data width
RD_LAT, 1, memory read latency in cycles (legal 1..15); mem_rdata is valid RD_LAT cycles after the mem_cs cycle

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
c_req  in  1  CPU access request, level; held until c_ack
c_we  in  1  CPU write (1) / read (0)
c_addr  in  ADDR_W  CPU address
c_wdata  in  DATA_W  CPU write data
c_ack  out  1  one-cycle completion pulse to CPU
c_rdata  out  DATA_W  CPU read data, valid while c_ack=1
d_req  in  1  DMA access request, level; held until d_ack
d_we  in  1  DMA write/read
d_addr  in  ADDR_W  DMA address
d_wdata  in  DATA_W  DMA write data
d_ack  out  1  one-cycle completion pulse to DMA
d_rdata  out  DATA_W  DMA read data, valid while d_ack=1
mem_cs  out  1  memory access strobe, exactly one cycle per access
mem_we  out  1  memory write enable, qualified by mem_cs
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in every state except IDLE
owner  out  1  current owner (0=CPU, 1=DMA); meaningful only while busy=1

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (rst=0, any time, including mid-access):
  - state -> IDLE; the in-flight access is aborted and no ack is issued.
  - All outputs 0: acks, mem_cs, mem_we, mem_addr, mem_wdata, rdata, busy, owner.
  - Internal capture registers and latency counter are cleared.
- IDLE:
  - Requests are sampled only in IDLE.
  - Any req high: select a winner, latch its we/addr/wdata and owner into internal registers, go to ISSUE.
  - No req: stay in IDLE.
  - Fixed priority: CPU wins ties.
- ISSUE (1 cycle):
  - mem_cs=1; mem_we/mem_addr/mem_wdata are driven from the latched registers.
  - Write -> RESP. Read -> WAIT with counter loaded to RD_LAT.
- WAIT:
  - Counter decrements each cycle; lasts exactly RD_LAT cycles.
  - On the final WAIT cycle, mem_rdata is captured into the owner's rdata register; go to RESP.
- RESP (1 cycle):
  - Owner's ack=1 and owner's rdata is held stable; go to IDLE.
  - A write's rdata output keeps its previous value.
- Latency, counted from the IDLE cycle in which req is sampled as cycle 0:
  - Read ack in cycle RD_LAT+2.
  - Write ack in cycle 2.
  - Next arbitration happens in the IDLE cycle after RESP.
- mem_cs is low outside ISSUE. mem_addr/mem_wdata hold their last values outside ISSUE.
- A requester's inputs may change after the IDLE sample without affecting the access in flight.
- A req still high in the IDLE cycle following its ack is treated as a new request.
- A req that rises while busy waits for IDLE; it is never lost and never acked early.
- The non-owner's ack is never asserted; acks are never simultaneous.
- Single-requester throughput: one read per RD_LAT+3 cycles, one write per 3 cycles.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN
- Defined: a last_owner register, reset to 1 (DMA), is updated in every RESP. On simultaneous C and D requests in IDLE, the winner is the requester that is not last_owner. A lone requester always wins.
- Undefined: strict fixed priority, CPU always wins ties; no last_owner register exists.

Test Plan:
- CPU read, RD_LAT=1: c_req=1, c_we=0, c_addr=0x005, memory[5]=0xA7 -> mem_cs high in cycle 1 with mem_addr=0x005; c_ack=1 and c_rdata=0xA7 in cycle 3; busy low in cycle 4.
- DMA write: d_req, d_we=1, d_addr=0x1F0, d_wdata=0x3C -> cycle 1 mem_cs=1, mem_we=1, mem_wdata=0x3C; d_ack in cycle 2; a follow-up CPU read of 0x1F0 returns 0x3C.
- Simultaneous requests, macro undefined: CPU read and DMA read asserted in the same cycle, held -> CPU acked first, then DMA; in a second back-to-back pair with CPU req held, CPU wins again. Macro defined: order is CPU, DMA, CPU, DMA alternating.
- RD_LAT=4: CPU read of 0x010 holding 0x55 -> c_ack in cycle 6 with 0x55; mem_cs high exactly one cycle; no ack in cycles 1-5.
- Reset mid-access: rst low during WAIT of a DMA read -> all outputs 0 immediately; after release, no d_ack occurs unless d_req is re-sampled in IDLE.
- Late request: d_req rises during a CPU WAIT -> the CPU access completes unaffected; the DMA access issues in the cycle after the next IDLE; exactly one d_ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified instruction/data memory port between the CPU (C) and a
//   DMA/debug loader (D). Each access is sampled in IDLE, issued for a single
//   cycle, waits out the fixed memory read latency (reads only) and completes
//   with a one-cycle ack to the requester that owns the access.
//
//   Optional build macro: MEM_ARB_ROUND_ROBIN_EN
//     defined   - simultaneous requests alternate, using a last_owner register
//     undefined - fixed priority, CPU wins ties
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata  CPU request (level, held until c_ack)
//   c_ack/c_rdata            CPU completion pulse and read data
//   d_req/d_we/d_addr/d_wdata  DMA request (level, held until d_ack)
//   d_ack/d_rdata            DMA completion pulse and read data
//   mem_cs/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
//   busy                     high whenever not IDLE
//   owner                    0 = CPU, 1 = DMA; valid while busy
module mem_port_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] LAT = 4'(RD_LAT);

    logic [1:0]        state;
    logic              we_q;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [3:0]        lat_cnt;
    logic              grant_d;   // DMA wins the current IDLE sample

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Starts as DMA so the first tie after reset goes to the CPU.
    logic last_owner;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_owner <= 1'b1;
        else if (state == S_RESP)
            last_owner <= owner_q;
    end

    // On a tie the requester that did not own the previous access wins.
    always_comb grant_d = d_req & (~c_req | ~last_owner);
`else
    always_comb grant_d = d_req & ~c_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
            lat_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // The request is captured here so the requester may change
                    // its inputs while the access is in flight.
                    if (c_req || d_req) begin
                        owner_q <= grant_d;
                        we_q    <= grant_d ? d_we    : c_we;
                        addr_q  <= grant_d ? d_addr  : c_addr;
                        wdata_q <= grant_d ? d_wdata : c_wdata;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (we_q) begin
                        state <= S_RESP;
                    end else begin
                        lat_cnt <= LAT;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    // Final wait cycle: memory data is valid now.
                    if (lat_cnt == 4'd1) begin
                        if (owner_q)
                            d_rdata_q <= mem_rdata;
                        else
                            c_rdata_q <= mem_rdata;
                        state <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Address/data come straight from the capture registers, so they only
    // change when a new access is issued and otherwise hold their last value.
    assign mem_cs    = (state == S_ISSUE);
    assign mem_we    = mem_cs & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign c_ack   = (state == S_RESP) & ~owner_q;
    assign d_ack   = (state == S_RESP) &  owner_q;
    assign c_rdata = c_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = (state != S_IDLE);
    assign owner   = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic clk, rst, preload;
    int   tests = 0;
    int   fails = 0;

    // DUT with RD_LAT=1
    logic        c_req, c_we, d_req, d_we;
    logic [12:0] c_addr, d_addr;
    logic [7:0]  c_wdata, d_wdata;
    logic        c_ack, d_ack, mem_cs, mem_we, busy, owner;
    logic [7:0]  c_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [12:0] mem_addr;

    // DUT with RD_LAT=4
    logic        c4_req, c4_we, d4_req, d4_we;
    logic [12:0] c4_addr, d4_addr;
    logic [7:0]  c4_wdata, d4_wdata;
    logic        c4_ack, d4_ack, m4_cs, m4_we, busy4, owner4;
    logic [7:0]  c4_rdata, d4_rdata, m4_wdata, m4_rdata;
    logic [12:0] m4_addr;

    mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .RD_LAT(4)) dut4 (
        .clk(clk), .rst(rst),
        .c_req(c4_req), .c_we(c4_we), .c_addr(c4_addr), .c_wdata(c4_wdata),
        .c_ack(c4_ack), .c_rdata(c4_rdata),
        .d_req(d4_req), .d_we(d4_we), .d_addr(d4_addr), .d_wdata(d4_wdata),
        .d_ack(d4_ack), .d_rdata(d4_rdata),
        .mem_cs(m4_cs), .mem_we(m4_we), .mem_addr(m4_addr),
        .mem_wdata(m4_wdata), .mem_rdata(m4_rdata),
        .busy(busy4), .owner(owner4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: read data is valid only RD_LAT cycles after the strobe
    // cycle and shows 0xEE otherwise, so latency errors become visible.
    logic [7:0] mem1 [0:8191];
    logic [7:0] rd1_q;
    logic       rv1_q;
    always @(posedge clk) begin
        if (preload) begin
            mem1[13'h005] <= 8'hA7;
            mem1[13'h010] <= 8'h55;
        end else if (mem_cs && mem_we) begin
            mem1[mem_addr] <= mem_wdata;
        end
        rd1_q <= mem1[mem_addr];
        rv1_q <= mem_cs && !mem_we;
    end
    assign mem_rdata = rv1_q ? rd1_q : 8'hEE;

    logic [7:0] mem4 [0:8191];
    logic [7:0] rd4 [0:3];
    logic [3:0] rv4;
    always @(posedge clk) begin
        if (preload)
            mem4[13'h010] <= 8'h55;
        else if (m4_cs && m4_we)
            mem4[m4_addr] <= m4_wdata;
        rd4[0] <= mem4[m4_addr];
        for (int i = 1; i < 4; i++) rd4[i] <= rd4[i-1];
        rv4 <= {rv4[2:0], m4_cs & ~m4_we};
    end
    assign m4_rdata = rv4[3] ? rd4[3] : 8'hEE;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests++;
        if ({c_ack, d_ack, mem_cs, mem_we, busy, owner, mem_addr, mem_wdata, c_rdata, d_rdata} !== '0) begin
            fails++;
            $display("FAIL reset_outputs_lat1: got %0h exp 0",
                     {c_ack, d_ack, mem_cs, mem_we, busy, owner, mem_addr, mem_wdata, c_rdata, d_rdata});
        end
        tests++;
        if ({c4_ack, d4_ack, m4_cs, m4_we, busy4, owner4, m4_addr, m4_wdata, c4_rdata, d4_rdata} !== '0) begin
            fails++;
            $display("FAIL reset_outputs_lat4: got %0h exp 0",
                     {c4_ack, d4_ack, m4_cs, m4_we, busy4, owner4, m4_addr, m4_wdata, c4_rdata, d4_rdata});
        end
    endtask

    task automatic test_cpu_read();
        c_req = 1; c_we = 0; c_addr = 13'h005; c_wdata = 8'h00;   // cycle 0
        tick();                                                    // cycle 1
        tests++;
        if (mem_cs !== 1'b1 || mem_addr !== 13'h005) begin
            fails++; $display("FAIL cpu_read_issue: cs=%0b addr=%0h exp cs=1 addr=5", mem_cs, mem_addr);
        end
        tick();                                                    // cycle 2
        tests++;
        if (c_ack !== 1'b0) begin fails++; $display("FAIL cpu_read_early_ack: got %0b exp 0", c_ack); end
        tick();                                                    // cycle 3
        tests++;
        if (c_ack !== 1'b1 || c_rdata !== 8'hA7) begin
            fails++; $display("FAIL cpu_read_ack: ack=%0b data=%0h exp ack=1 data=a7", c_ack, c_rdata);
        end
        c_req = 0;
        tick();                                                    // cycle 4
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL cpu_read_idle: busy=%0b exp 0", busy); end
    endtask

    task automatic test_dma_write();
        d_req = 1; d_we = 1; d_addr = 13'h1F0; d_wdata = 8'h3C;    // cycle 0
        tick();                                                    // cycle 1
        tests++;
        if ({mem_cs, mem_we, mem_wdata, mem_addr, owner} !== {1'b1, 1'b1, 8'h3C, 13'h1F0, 1'b1}) begin
            fails++; $display("FAIL dma_write_issue: cs=%0b we=%0b wd=%0h addr=%0h own=%0b exp 1 1 3c 1f0 1",
                              mem_cs, mem_we, mem_wdata, mem_addr, owner);
        end
        tick();                                                    // cycle 2
        tests++;
        if (d_ack !== 1'b1 || c_ack !== 1'b0 || d_rdata !== 8'h00) begin
            fails++; $display("FAIL dma_write_ack: d_ack=%0b c_ack=%0b d_rdata=%0h exp 1 0 0", d_ack, c_ack, d_rdata);
        end
        d_req = 0; d_we = 0;
        tick();                                                    // cycle 3
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL dma_write_idle: busy=%0b exp 0", busy); end
        c_req = 1; c_we = 0; c_addr = 13'h1F0;
        repeat (3) tick();
        tests++;
        if (c_ack !== 1'b1 || c_rdata !== 8'h3C) begin
            fails++; $display("FAIL readback_1f0: ack=%0b data=%0h exp ack=1 data=3c", c_ack, c_rdata);
        end
        c_req = 0;
        tick();
    endtask

    task automatic test_simultaneous();
        int c_cyc, d_cyc, n, both;
        logic [2:0] seq, exp_seq;
        int ack_cyc [3];
        // Fresh reset so round-robin history is known.
        rst = 0; tick(); rst = 1; tick();
        c_cyc = 0; d_cyc = 0; both = 0;
        c_req = 1; c_we = 0; c_addr = 13'h005;
        d_req = 1; d_we = 0; d_addr = 13'h010;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (c_ack && d_ack) both++;
            if (c_ack) begin c_cyc = cyc; c_req = 0; end
            if (d_ack) begin
                d_cyc = cyc; d_req = 0;
                tests++;
                if (d_rdata !== 8'h55) begin fails++; $display("FAIL sim_dma_data: got %0h exp 55", d_rdata); end
                break;
            end
        end
        tests++;
        if (c_cyc != 3 || d_cyc != 7) begin
            fails++; $display("FAIL sim_order: c_ack cyc %0d d_ack cyc %0d exp 3 and 7", c_cyc, d_cyc);
        end
        tick();
        // Second pair: CPU request stays up across its own ack.
        n = 0; seq = '0;
        c_req = 1; d_req = 1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            if (c_ack && d_ack) both++;
            if (c_ack || d_ack) begin
                seq[n] = d_ack; ack_cyc[n] = cyc; n++;
                if (n == 3) begin c_req = 0; d_req = 0; break; end
            end
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_seq = 3'b010;
`else
        exp_seq = 3'b000;
`endif
        tests++;
        if (n != 3 || seq !== exp_seq) begin
            fails++; $display("FAIL sim_pair2_order: acks=%0d seq=%03b exp 3 acks seq=%03b", n, seq, exp_seq);
        end
        tests++;
        if (n != 3 || ack_cyc[0] != 3 || ack_cyc[1] != 7 || ack_cyc[2] != 11) begin
            fails++; $display("FAIL sim_throughput: ack cycles %0d %0d %0d exp 3 7 11", ack_cyc[0], ack_cyc[1], ack_cyc[2]);
        end
        tests++;
        if (both != 0) begin fails++; $display("FAIL sim_dual_ack: got %0d exp 0", both); end
        tick();
    endtask

    task automatic test_rd_lat4();
        int cs_cnt, cs_cyc, ack_cnt, ack_cyc;
        logic [7:0] ack_data;
        cs_cnt = 0; cs_cyc = 0; ack_cnt = 0; ack_cyc = 0; ack_data = '0;
        c4_req = 1; c4_we = 0; c4_addr = 13'h010;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            tick();
            if (m4_cs) begin cs_cnt++; cs_cyc = cyc; end
            if (c4_ack) begin ack_cnt++; ack_cyc = cyc; ack_data = c4_rdata; c4_req = 0; end
        end
        tests++;
        if (cs_cnt != 1 || cs_cyc != 1) begin
            fails++; $display("FAIL lat4_cs: count %0d cyc %0d exp 1 and 1", cs_cnt, cs_cyc);
        end
        tests++;
        if (ack_cnt != 1 || ack_cyc != 6 || ack_data !== 8'h55) begin
            fails++; $display("FAIL lat4_ack: count %0d cyc %0d data %0h exp 1 6 55", ack_cnt, ack_cyc, ack_data);
        end
        tests++;
        if (busy4 !== 1'b0) begin fails++; $display("FAIL lat4_idle: busy=%0b exp 0", busy4); end
    endtask

    task automatic test_reset_mid();
        int acks;
        d_req = 1; d_we = 0; d_addr = 13'h005; d_wdata = 8'h99;    // cycle 0
        tick();                                                    // cycle 1 ISSUE
        tick();                                                    // cycle 2 WAIT
        rst = 0;
        #1;
        tests++;
        if ({c_ack, d_ack, mem_cs, mem_we, busy, owner, mem_addr, mem_wdata, c_rdata, d_rdata} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %0h exp 0",
                     {c_ack, d_ack, mem_cs, mem_we, busy, owner, mem_addr, mem_wdata, c_rdata, d_rdata});
        end
        d_req = 0;
        tick();
        rst = 1;
        acks = 0;
        repeat (8) begin tick(); if (d_ack) acks++; end
        tests++;
        if (acks != 0) begin fails++; $display("FAIL reset_mid_no_ack: got %0d acks exp 0", acks); end
        d_req = 1;
        repeat (3) tick();
        tests++;
        if (d_ack !== 1'b1 || d_rdata !== 8'hA7) begin
            fails++; $display("FAIL reset_mid_resample: ack=%0b data=%0h exp 1 a7", d_ack, d_rdata);
        end
        d_req = 0;
        tick();
    endtask

    task automatic test_late_request();
        int c_acks, d_acks, c_cyc, d_cyc, d_iss;
        logic [7:0] d_data;
        c_acks = 0; d_acks = 0; c_cyc = 0; d_cyc = 0; d_iss = 0; d_data = '0;
        c_req = 1; c_we = 0; c_addr = 13'h005;                     // cycle 0
        tick(); tick();                                            // cycle 2 (WAIT)
        d_req = 1; d_we = 0; d_addr = 13'h1F0;
        for (int cyc = 3; cyc <= 14; cyc++) begin
            tick();
            if (c_ack) begin c_acks++; c_cyc = cyc; c_req = 0; end
            if (d_ack) begin d_acks++; d_cyc = cyc; d_data = d_rdata; d_req = 0; end
            if (mem_cs && owner && d_iss == 0) d_iss = cyc;
        end
        tests++;
        if (c_acks != 1 || c_cyc != 3 || c_rdata !== 8'hA7) begin
            fails++; $display("FAIL late_cpu: acks %0d cyc %0d data %0h exp 1 3 a7", c_acks, c_cyc, c_rdata);
        end
        tests++;
        if (d_iss != 5) begin fails++; $display("FAIL late_dma_issue: cyc %0d exp 5", d_iss); end
        tests++;
        if (d_acks != 1 || d_cyc != 7 || d_data !== 8'h3C) begin
            fails++; $display("FAIL late_dma_ack: acks %0d cyc %0d data %0h exp 1 7 3c", d_acks, d_cyc, d_data);
        end
    endtask

    initial begin
        rst = 0; preload = 1;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        c4_req = 0; c4_we = 0; c4_addr = '0; c4_wdata = '0;
        d4_req = 0; d4_we = 0; d4_addr = '0; d4_wdata = '0;
        repeat (3) tick();
        preload = 0;
        test_reset();
        rst = 1;
        tick();
        test_cpu_read();
        test_dma_write();
        test_simultaneous();
        test_rd_lat4();
        test_reset_mid();
        test_late_request();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, exp completion");
        $fatal(1, "timeout");
    end

endmodule
